// File: rtl/fft64_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft64_pkg
// Brief    : Shared constants and schedule helpers for the 64-point SDF FFT.
// Revision : 1.0
// ============================================================================
package fft64_pkg;

    localparam int LOG2N    = 6;
    localparam int N        = 64;
    localparam int TW_IDX_W = 5;

    // Feedback delay-line depth of stage k: 32, 16, 8, 4, 2, 1.
    function automatic int stage_delay(input int k);
        return (N / 2) >> k;
    endfunction

    // ce-cycles between the global counter and stage k's local count.
    function automatic int stage_offset(input int k, input int stg_lat);
        int acc;
        acc = 0;
        for (int j = 0; j < k; j++) begin
            acc += stage_delay(j) + stg_lat;
        end
        return acc;
    endfunction

    function automatic int tot_lat(input int stg_lat);
        return stage_offset(LOG2N, stg_lat);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sched
// Brief    : Maps the global sample count to one stage's phase and twiddle.
// Revision : 1.0
// ============================================================================
module fft_stage_sched
    import fft64_pkg::*;
#(
    parameter int K      = 0,
    parameter int OFFSET = 0,
    parameter int TW_W   = TW_IDX_W
) (
    input  logic [LOG2N-1:0] g,
    output logic             bf_sel,
    output logic [TW_W-1:0]  tw_idx
);

    localparam logic [LOG2N-1:0] c_OFF     = LOG2N'(OFFSET % N);
    localparam logic [LOG2N-1:0] c_BF_MASK = LOG2N'(1 << (LOG2N - 1 - K));
    localparam logic [LOG2N-1:0] c_TW_MASK = LOG2N'((1 << (LOG2N - 1 - K)) - 1);

    logic [LOG2N-1:0] w_s;

    assign w_s    = g - c_OFF;
    assign bf_sel = |(w_s & c_BF_MASK);
    // Last stage has an empty mask, so its twiddle index is constant zero.
    assign tw_idx = bf_sel ? '0 : TW_W'((w_s & c_TW_MASK) << K);

endmodule
`default_nettype wire

// File: rtl/fft64_sdf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft64_sdf_ctrl
// Brief    : Global sequencer for the 64-point radix-2 DIF SDF FFT pipeline.
// Revision : 1.0
// ============================================================================
module fft64_sdf_ctrl
    import fft64_pkg::*;
#(
    parameter int STG_LAT = 1,
    parameter int TW_W    = TW_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    ce,
    output logic                    din_zero,
    output logic [LOG2N-1:0]        bf_sel,
    output logic [LOG2N*TW_W-1:0]   tw_idx,
    output logic                    out_valid,
    output logic [LOG2N-1:0]        out_idx,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic                    busy
);

    localparam int               c_TOT     = tot_lat(STG_LAT);
    localparam logic [LOG2N-1:0] c_TOT_MOD = LOG2N'(c_TOT % N);

    logic [LOG2N-1:0] r_g;
    logic [c_TOT-1:0] r_vpipe;
    logic             r_drain;

    logic w_g_zero;
    logic w_any;
    logic w_accept;
    logic w_drain_step;

    assign w_g_zero  = (r_g == '0);
    assign w_any     = |r_vpipe;
    assign in_ready  = !r_drain || w_g_zero;
    assign w_accept  = in_valid && in_ready;
    // At a frame boundary drain only while tokens remain; otherwise keep
    // stepping until the counter realigns to zero.
    assign w_drain_step = w_g_zero ? (!in_valid && w_any) : r_drain;
    assign ce        = w_accept || w_drain_step;
    assign din_zero  = ce && !w_accept;
    assign out_valid = ce && r_vpipe[c_TOT-1];
    assign out_idx   = r_g - c_TOT_MOD;
    assign out_sof   = out_valid && (out_idx == '0);
    assign out_eof   = out_valid && (out_idx == '1);
    assign busy      = w_any || r_drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_g     <= '0;
            r_vpipe <= '0;
            r_drain <= 1'b0;
        end else begin
            if (ce) begin
                r_g     <= r_g + LOG2N'(1);
                r_vpipe <= {r_vpipe[c_TOT-2:0], w_accept};
            end
            if (w_g_zero) begin
                r_drain <= w_drain_step && !w_accept;
            end
        end
    end

    for (genvar k = 0; k < LOG2N; k++) begin : g_stage
        fft_stage_sched #(
            .K      (k),
            .OFFSET (stage_offset(k, STG_LAT)),
            .TW_W   (TW_W)
        ) u_sched (
            .g      (r_g),
            .bf_sel (bf_sel[k]),
            .tw_idx (tw_idx[k*TW_W +: TW_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_fft64_sdf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft64_sdf_ctrl
// Brief    : Scoreboard bench for the FFT sequencer (order, flags, latency).
// Revision : 1.0
// ============================================================================
module tb_fft64_sdf_ctrl;

    localparam int c_TOT = 69;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ce;
    logic        din_zero;
    logic [5:0]  bf_sel;
    logic [29:0] tw_idx;
    logic        out_valid;
    logic [5:0]  out_idx;
    logic        out_sof;
    logic        out_eof;
    logic        busy;

    typedef struct {
        int idx;
        int due;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ce_count = 0;

    fft64_sdf_ctrl #(.STG_LAT(1), .TW_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ce        (ce),
        .din_zero  (din_zero),
        .bf_sel    (bf_sel),
        .tw_idx    (tw_idx),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one sample and record where it must reappear.
    task automatic send(input int idx, input int extra);
        @(negedge clk);
        in_valid = 1'b1;
        q.push_back('{idx, cyc + c_TOT + extra});
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            idle_cycle();
            #3;
            if (!busy) break;
        end
        check("drain_done", busy, 0);
    endtask

    // Monitor: pops and compares whenever the DUT presents an output.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (ce === 1'b1) ce_count++;
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_idx", out_idx, e.idx);
                    check("out_sof", out_sof, e.idx == 0);
                    check("out_eof", out_eof, e.idx == 63);
                    check("out_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ce0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) idle_cycle();
        #3;
        check("idle_in_ready", in_ready, 1);
        check("idle_ce", ce, 0);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_din_zero", din_zero, 0);
        check("idle_sof_eof", {out_sof, out_eof}, 0);
        check("idle_bf_sel_g0", bf_sel, 6'b101110);
        check("idle_tw_idx_g0", tw_idx, 0);

        // Single frame, then drain to the frame boundary
        ce0 = ce_count;
        for (int i = 0; i < 64; i++) begin
            send(i, 0);
            #3;
            if (i == 0) begin
                check("f1_ce", ce, 1);
                check("f1_in_ready", in_ready, 1);
            end
            if (i == 40) begin
                check("g40_bf_sel", bf_sel, 6'b101001);
                check("g40_tw0", tw_idx[4:0], 0);
                check("g40_tw1", tw_idx[9:5], 14);
                check("g40_tw2", tw_idx[14:10], 24);
            end
        end
        wait_idle(400);
        check("f1_ce_total", ce_count - ce0, 192);
        check("f1_out_idx_g0", out_idx, 59);
        check("f1_ce_after", ce, 0);

        // Mid-frame stall at g=10 for 5 cycles
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                for (int s = 0; s < 5; s++) begin
                    idle_cycle();
                    #3;
                    if (s == 0 || s == 4) begin
                        check("stall_ce", ce, 0);
                        check("stall_bf_sel", bf_sel, 6'b111100);
                        check("stall_tw_idx", tw_idx, 586);
                        check("stall_din_zero", din_zero, 0);
                    end
                end
            end
            send(i, (i < 10) ? 5 : 0);
        end
        wait_idle(400);

        // Back-to-back frames
        for (int i = 0; i < 128; i++) begin
            send(i % 64, 0);
            #3;
            if (i == 64) begin
                check("b2b_ce", ce, 1);
                check("b2b_in_ready", in_ready, 1);
                check("b2b_din_zero", din_zero, 0);
            end
        end
        wait_idle(400);

        // New input arriving during drain is held off to the boundary
        for (int i = 0; i < 64; i++) send(i, 0);
        repeat (20) idle_cycle();
        @(negedge clk);
        in_valid = 1'b1;
        #3;
        check("drain_in_ready", in_ready, 0);
        check("drain_din_zero", din_zero, 1);
        check("drain_ce", ce, 1);
        repeat (43) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                repeat (2) begin
                    idle_cycle();
                    #3;
                    check("post_drain_stall_ce", ce, 0);
                end
            end
            send(i, (i < 10) ? 2 : 0);
            #3;
            if (i == 0) begin
                check("boundary_in_ready", in_ready, 1);
                check("boundary_din_zero", din_zero, 0);
            end
        end
        wait_idle(400);

        // Reset while busy discards everything in flight
        for (int i = 0; i < 20; i++) send(i, 0);
        idle_cycle();
        #3;
        check("pre_reset_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("post_reset_busy", busy, 0);
        check("post_reset_out_idx", out_idx, 59);
        check("post_reset_ce", ce, 0);
        check("post_reset_in_ready", in_ready, 1);

        repeat (5) idle_cycle();
        check("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
